// File: rtl/belief_update.sv
// -----------------------------------------------------------------------------
// belief_update
//
// Two-state POMDP belief update in unsigned fixed point (1.0 ~ 2**W).
// On an en_belief pulse the block predicts the next-state distribution
// through the transition table and weights it with the observation
// likelihood. It then normalises state 0 with a W-cycle restoring divider.
// belief1 is implicit: 2**W - belief0.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   en_belief    start pulse (sampled in IDLE only)
//   observation  observed symbol o
//   action       action a (0..2 legal; 3 is rejected)
//   trans        P(to | from, a),     indexed [a][from][to]
//   observe      P(obs | state, a),   indexed [a][state][obs]
//   load         load init_belief as prior (IDLE only, wins over en_belief)
//   init_belief  prior value for belief0
//   belief0      current P(state = 0)
//   busy         high in every state except IDLE
//   done         one-cycle pulse at the end of an update
//   err          qualifies done: update rejected, belief0 unchanged
// -----------------------------------------------------------------------------
module belief_update #(
    parameter int W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_belief,
    input  logic                         observation,
    input  logic [1:0]                   action,
    input  logic [2:0][1:0][1:0][W-1:0]  trans,
    input  logic [2:0][1:0][1:0][W-1:0]  observe,
    input  logic                         load,
    input  logic [W-1:0]                 init_belief,
    output logic [W-1:0]                 belief0,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRED = 2'd1,
        WGT  = 2'd2,
        DIV  = 2'd3
    } state_t;

    localparam int            CW       = $clog2(W);
    localparam logic [CW-1:0] LAST     = CW'(W - 1);
    localparam logic [W:0]    ONE      = {1'b1, {W{1'b0}}};
    localparam logic [W-1:0]  HALF     = {1'b1, {(W-1){1'b0}}};

    state_t              state_q;
    logic [W-1:0]        belief0_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic [1:0]          act_q;
    logic                obs_q;
    logic [1:0][W:0]     pred_q;
    logic [W+2:0]        rem_q;
    logic [W+1:0]        div_q;
    logic [W-1:0]        quo_q;
    logic                sat_q;
    logic [CW-1:0]       cnt_q;

    logic [1:0]          a_idx;
    logic [W:0]          b1;
    logic [1:0][W:0]     pred_d;
    logic [1:0][W:0]     u_d;
    logic [W+1:0]        n_d;
    logic [W+2:0]        rem_d;
    logic [W-1:0]        quo_d;

    // Action 3 is rejected in WGT anyway; folding it onto row 0 keeps the
    // table reads inside the declared range.
    assign a_idx = (act_q == 2'd3) ? 2'd0 : act_q;
    assign b1    = ONE - {1'b0, belief0_q};

    // Prediction, observation weighting and one divider step.
    // NOTE: every always_comb output is assigned a default before any branch,
    // so no path leaves a value held and no latch is inferred.
    always_comb begin
        logic [2*W+1:0] acc;
        logic [W+1:0]   acc_sh;
        logic [2*W:0]   prod;
        logic [W+2:0]   rem_sh;

        pred_d = '0;
        u_d    = '0;
        for (int s = 0; s < 2; s++) begin
            acc    = (2*W+2)'(trans[a_idx][0][s]) * (2*W+2)'({1'b0, belief0_q})
                   + (2*W+2)'(trans[a_idx][1][s]) * (2*W+2)'(b1);
            acc_sh = (W+2)'(acc >> W);
            pred_d[s] = (acc_sh > (W+2)'(ONE)) ? ONE : acc_sh[W:0];

            prod   = (2*W+1)'(pred_q[s]) * (2*W+1)'(observe[a_idx][s][obs_q]);
            u_d[s] = (W+1)'(prod >> W);
        end
        n_d = (W+2)'(u_d[0]) + (W+2)'(u_d[1]);

        // Restoring step: shift the partial remainder, subtract if it fits.
        rem_sh = rem_q << 1;
        if (rem_sh >= (W+3)'(div_q)) begin
            rem_d = rem_sh - (W+3)'(div_q);
            quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
            rem_d = rem_sh;
            quo_d = {quo_q[W-2:0], 1'b0};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    // NOTE: only control state and belief0 are reset; the datapath registers
    // are always written before they are read, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            belief0_q <= HALF;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        belief0_q <= init_belief;
                    end else if (en_belief) begin
                        act_q   <= action;
                        obs_q   <= observation;
                        busy_q  <= 1'b1;
                        state_q <= PRED;
                    end
                end
                PRED: begin
                    pred_q  <= pred_d;
                    state_q <= WGT;
                end
                WGT: begin
                    if (n_d == '0 || act_q == 2'd3) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        rem_q   <= (W+3)'(u_d[0]);
                        div_q   <= n_d;
                        quo_q   <= '0;
                        // u0 == n means the quotient is exactly 1.0, which
                        // does not fit in W bits; the divider runs anyway.
                        sat_q   <= ((W+2)'(u_d[0]) >= n_d);
                        cnt_q   <= '0;
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        belief0_q <= sat_q ? {W{1'b1}} : quo_d;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign belief0 = belief0_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_belief_update.sv
// -----------------------------------------------------------------------------
// tb_belief_update
//
// Self-checking bench for belief_update. Each started update pushes its
// expected belief0, err and done cycle onto a scoreboard queue; a negedge
// monitor pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_belief_update;

    localparam int W = 16;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        en_belief;
    logic                        observation;
    logic [1:0]                  action;
    logic [2:0][1:0][1:0][W-1:0] trans;
    logic [2:0][1:0][1:0][W-1:0] observe;
    logic                        load;
    logic [W-1:0]                init_belief;
    logic [W-1:0]                belief0;
    logic                        busy;
    logic                        done;
    logic                        err;

    always #5 clk = ~clk;

    belief_update #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en_belief   (en_belief),
        .observation (observation),
        .action      (action),
        .trans       (trans),
        .observe     (observe),
        .load        (load),
        .init_belief (init_belief),
        .belief0     (belief0),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    typedef struct {
        logic [W-1:0] b;
        logic         e;
        int           at;
    } exp_t;

    exp_t         sb[$];
    int           n_vec  = 0;
    int           n_miss = 0;
    int           cyc    = 0;
    logic [W-1:0] bel_model;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference model written directly from the arithmetic definition,
    // using a plain integer divide.
    function automatic void model(input logic [W-1:0] b0, input int a, input int o,
                                  output logic [W-1:0] nb, output logic e);
        longint b1, p, n, q;
        longint u[2];
        nb = b0;
        e  = 1'b1;
        if (a == 3) return;
        b1 = 65536 - longint'(b0);
        for (int s = 0; s < 2; s++) begin
            p = (longint'(trans[a][0][s]) * longint'(b0)
               + longint'(trans[a][1][s]) * b1) >> 16;
            if (p > 65536) p = 65536;
            u[s] = (p * longint'(observe[a][s][o])) >> 16;
        end
        n = u[0] + u[1];
        if (n == 0) return;
        q = (u[0] << 16) / n;
        if (q > 65535) q = 65535;
        nb = q[15:0];
        e  = 1'b0;
    endfunction

    always @(negedge clk) begin
        exp_t x;
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 0);
            end else begin
                x = sb.pop_front();
                check("belief0", 32'(belief0), 32'(x.b));
                check("err", 32'(err), 32'(x.e));
                check("done_cycle", 32'(cyc), 32'(x.at));
                check("busy_at_done", 32'(busy), 0);
            end
        end
    end

    task automatic set_tables(input logic [W-1:0] o10, input logic [W-1:0] o11);
        for (int a = 0; a < 3; a++) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    trans[a][i][j] = 16'h8000;
            observe[a][0][0] = 16'hC000;
            observe[a][0][1] = 16'h4000;
            observe[a][1][0] = o10;
            observe[a][1][1] = o11;
        end
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load        = 1'b1;
        init_belief = v;
        @(negedge clk);
        load      = 1'b0;
        bel_model = v;
        check("load", 32'(belief0), 32'(v));
    endtask

    // Drives one en_belief pulse; returns at the negedge after E0.
    task automatic start(input int a, input int o);
        exp_t         x;
        logic [W-1:0] nb;
        logic         e;
        model(bel_model, a, o, nb, e);
        en_belief   = 1'b1;
        action      = 2'(a);
        observation = 1'(o);
        @(negedge clk);
        en_belief = 1'b0;
        x.b  = nb;
        x.e  = e;
        x.at = cyc + (e ? 2 : 18);
        sb.push_back(x);
        if (!e) bel_model = nb;
        check("busy_after_start", 32'(busy), 1);
    endtask

    task automatic wait_done();
        int k = 0;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) begin
            check("done_timeout", 0, 1);
            sb.delete();
        end
    endtask

    initial begin
        rst         = 1'b1;
        en_belief   = 1'b0;
        load        = 1'b0;
        observation = 1'b0;
        action      = 2'd0;
        init_belief = '0;
        set_tables(16'h4000, 16'hC000);
        repeat (3) @(negedge clk);
        check("rst_belief0", 32'(belief0), 32'h8000);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        rst       = 1'b0;
        bel_model = 16'h8000;

        // Symmetric tables, o=0 then o=1.
        start(0, 0); wait_done();
        do_load(16'h8000);
        start(1, 1); wait_done();

        // Back-to-back: the second pulse is raised in the done cycle.
        do_load(16'h8000);
        start(2, 0); wait_done();
        start(2, 1); wait_done();

        // u0 == n saturates to 0xFFFF.
        set_tables(16'h0000, 16'hC000);
        do_load(16'h8000);
        start(0, 0); wait_done();

        // All-zero likelihoods -> rejected, busy low afterwards.
        for (int a = 0; a < 3; a++) observe[a] = '0;
        start(1, 0); wait_done();
        @(negedge clk);
        check("busy_after_reject", 32'(busy), 0);

        // Illegal action 3 -> rejected.
        set_tables(16'h4000, 16'hC000);
        start(3, 0); wait_done();
        @(negedge clk);
        check("busy_after_act3", 32'(busy), 0);

        // en_belief and load pulsed mid-division are ignored.
        do_load(16'h8000);
        start(0, 0);
        repeat (8) @(negedge clk);
        en_belief   = 1'b1;
        load        = 1'b1;
        init_belief = 16'h1234;
        action      = 2'd2;
        observation = 1'b1;
        @(negedge clk);
        en_belief = 1'b0;
        load      = 1'b0;
        check("belief0_mid_div", 32'(belief0), 32'h8000);
        wait_done();

        // load and en_belief together in IDLE: load wins.
        @(negedge clk);
        load        = 1'b1;
        en_belief   = 1'b1;
        init_belief = 16'h3000;
        @(negedge clk);
        load      = 1'b0;
        en_belief = 1'b0;
        bel_model = 16'h3000;
        check("load_wins_belief0", 32'(belief0), 32'h3000);
        check("load_wins_busy0", 32'(busy), 0);
        @(negedge clk);
        check("load_wins_busy1", 32'(busy), 0);

        // Random tables and priors chained through successive updates.
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < 3; a++)
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++) begin
                        trans[a][i][j]   = 16'($urandom_range(0, 65535));
                        observe[a][i][j] = 16'($urandom_range(0, 65535));
                    end
            start(int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
            wait_done();
        end

        // Reset at E10 aborts the update without a done pulse.
        set_tables(16'h4000, 16'hC000);
        do_load(16'h3000);
        start(0, 0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        bel_model = 16'h8000;
        check("abort_belief0", 32'(belief0), 32'h8000);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        repeat (25) @(negedge clk);

        // Normal operation resumes after the abort.
        start(0, 0); wait_done();
        @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/belief_update.md
BELIEF_UPDATE -- requirements
Module: belief_update

Interface
REQ-001 Parameter SHALL be W, default 16, meaning the width of probability words in unsigned Q0.16 (0xFFFF ~ 1.0).
REQ-002 Port clk SHALL be input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-003 Port rst SHALL be input, 1 bit: reset, synchronous and active-high.
REQ-004 Port en_belief SHALL be input, 1 bit: start pulse from the observation generator.
REQ-005 Port observation SHALL be input, 1 bit: the observed symbol o.
REQ-006 Port action SHALL be input, 2 bits: the action taken; legal values are 0 to 2.
REQ-007 Port trans SHALL be input [W-1:0] [2:0][1:0][1:0], indexed [action][from][to]: P(to | from, action).
REQ-008 Port observe SHALL be input [W-1:0] [2:0][1:0][1:0], indexed [action][state][obs]: P(obs | state, action).
REQ-009 Port load SHALL be input, 1 bit: load init_belief as the prior.
REQ-010 Port init_belief SHALL be input, W bits: the prior value of b0.
REQ-011 Port belief0 SHALL be output, W bits: current P(state=0); b1 is implied as 0x10000 - belief0.
REQ-012 Port busy SHALL be output, 1 bit: high while an update is in progress.
REQ-013 Port done SHALL be output, 1 bit: one-cycle pulse when an update ends.
REQ-014 Port err SHALL be output, 1 bit: qualifies done; set when the update was rejected.

Function
REQ-015 FSM states SHALL be IDLE, PRED, WGT, DIV; busy SHALL be 1 in every state except IDLE.
REQ-016 IDLE actions:
- load=1: belief0 <= init_belief.
- load=0 and en_belief=1: latch action and observation, then go to PRED.
- load=1 and en_belief=1 together: load wins and en_belief is dropped.
REQ-017 en_belief, load, action and observation SHALL be ignored outside IDLE; tables SHALL be held stable by the user while busy=1.
REQ-018 PRED SHALL compute, for each s' in {0,1}, a 17-bit prediction:
- pred[s'] = (T[a][0][s']*b0 + T[a][1][s']*b1) >> 16, with b1 = 0x10000 - b0 (17 bits).
- Result saturates at 0x10000; then go to WGT.
REQ-019 WGT SHALL compute, then branch:
- u[s'] = (pred[s'] * observe[a][s'][o]) >> 16, 17 bits each; n = u0 + u1, 18 bits.
- n != 0 and latched action <= 2: go to DIV.
- n == 0 or latched action == 3: assert done=1 and err=1 for one cycle, leave belief0 unchanged, return to IDLE.
REQ-020 DIV SHALL run a restoring divider for exactly 16 cycles, producing q = floor((u0 << 16) / n).
REQ-021 On the 16th DIV cycle the block SHALL, in the same edge:
- write belief0 <= min(q, 0xFFFF); u0 == n SHALL give 0xFFFF.
- assert done=1 with err=0 for one cycle, then return to IDLE.
REQ-022 Latency, counted from the edge that samples en_belief as edge E0:
- normal update: done high in the cycle after E18.
- rejected update: done high in the cycle after E2.
REQ-023 A new en_belief SHALL be accepted in the cycle in which done is high (the FSM is then in IDLE).
REQ-024 belief0 SHALL change only on load or on a successful update, never mid-division.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL set state=IDLE, belief0=0x8000, busy=0, done=0 and err=0.
REQ-026 Reset during PRED, WGT or DIV SHALL abort the update with no done pulse, and belief0 SHALL be 0x8000.
REQ-027 rst SHALL have priority over load and en_belief in the same cycle.

Verification
REQ-028 Common setup for the first three scenarios: b0=0x8000; all trans entries 0x8000; observe[a][0][0]=0xC000, observe[a][0][1]=0x4000.
REQ-029 Scenario 1: observe[a][1][0]=0x4000, observe[a][1][1]=0xC000, o=0, en_belief pulse -> done after E18, err=0, belief0=0xC000.
REQ-030 Scenario 2: same tables as scenario 1, o=1 -> belief0=0x4000, done after E18, err=0.
REQ-031 Scenario 3: observe[a][1][0]=0, o=0 -> u0 == n, belief0=0xFFFF (saturated), err=0.
REQ-032 Scenario 4: all observe entries 0, or action=3 -> done and err high after E2, belief0 unchanged, busy low the next cycle.
REQ-033 Scenario 5 (ignored inputs): en_belief and load pulsed during DIV -> ignored, result as scenario 1; load=1 with en_belief=1 in IDLE and init_belief=0x3000 -> belief0=0x3000, busy stays 0.
REQ-034 Scenario 6 (reset mid-operation): rst asserted at E10 of an update -> no done pulse, belief0=0x8000, busy=0 from the next cycle.
